dac_wave_gen: RTL and testbench

//  BCD-programmed DDS waveform generator driving a 10-bit DAC; the transmit-side counterpart of the AD frequency meter.

---
 rtl/dac_wave_gen_pkg.sv | 41 ++++
 rtl/dac_wave_gen_sine_lut.sv | 36 +++
 rtl/dac_wave_gen.sv | 189 ++++++++++++++++++
 tb/tb_dac_wave_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_wave_gen_pkg.sv
// Shared encodings and helpers for the BCD-programmed DDS generator dac_wave_gen.
// The sine helper is only referenced when WAVE_SINE_EN is defined.
package dac_wave_gen_pkg;

  localparam int DAC_W      = 10;
  localparam int BCD_DIGITS = 7;
  localparam int BIN_W      = 24;

  typedef enum logic [1:0] {
    WAVE_SQR = 2'd0,
    WAVE_SAW = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_SIN = 2'd3
  } wave_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_SCALE  = 2'd2,
    ST_COMMIT = 2'd3
  } conv_state_e;

  function automatic logic bcd_invalid(input logic [4*BCD_DIGITS-1:0] digits);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      bad = bad | (digits[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // 512 + 511*sin(pi/2 * idx/256), evaluated as a Taylor series up to x^9.
  function automatic logic [DAC_W-1:0] sine_quarter(input int idx);
    real x, x2, s;
    x  = 1.5707963267948966 * real'(idx) / 256.0;
    x2 = x * x;
    s  = x * (1.0 - x2 / 6.0 * (1.0 - x2 / 20.0 * (1.0 - x2 / 42.0 * (1.0 - x2 / 72.0))));
    return DAC_W'(512 + int'(s * 511.0));
  endfunction

endpackage

// File: rtl/dac_wave_gen_sine_lut.sv
// Registered quarter-wave sine ROM, 256 x 10-bit offset-binary (512..1023).
// Compiled only when WAVE_SINE_EN is defined.
`ifdef WAVE_SINE_EN
module dac_sine_lut
  import dac_wave_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       addr,
  output logic [DAC_W-1:0] data
);

  logic [DAC_W-1:0] rom [256];
  logic [DAC_W-1:0] data_d;
  logic [DAC_W-1:0] data_q;

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign rom[i] = sine_quarter(i);
  end

  always_comb begin
    data_d = rom[addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= {DAC_W{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule
`endif

// File: rtl/dac_wave_gen.sv
// BCD-programmed DDS waveform generator for a 10-bit DAC with a sync square output.
// Define WAVE_SINE_EN to enable the quarter-wave sine LUT on wave_sel=3.
module dac_wave_gen
  import dac_wave_gen_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int ACC_W    = 32,
  parameter int HZ_SCALE = 2814750,
  parameter int FMAX     = 9_999_999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       FRE0,
  input  logic [3:0]       FRE1,
  input  logic [3:0]       FRE2,
  input  logic [3:0]       FRE3,
  input  logic [3:0]       FRE4,
  input  logic [3:0]       FRE5,
  input  logic [3:0]       FRE6,
  input  logic             load,
  input  logic [1:0]       wave_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [DAC_W-1:0] dac_out,
  output logic             sync_out
);

  localparam int                PROD_W   = ACC_W + 16;
  localparam logic [BIN_W-1:0]  FMAX_BIN = BIN_W'(FMAX);
  localparam logic [PROD_W-1:0] SCALE_W  = PROD_W'(HZ_SCALE);

  if (CLK_HZ <= 0 || HZ_SCALE <= 0 || FMAX >= (1 << BIN_W)) begin : g_cfg_check
    $error("dac_wave_gen: inconsistent CLK_HZ/HZ_SCALE/FMAX");
  end

  conv_state_e             state_q, state_d;
  logic [4*BCD_DIGITS-1:0] dig_q, dig_d, fre_s;
  logic [2:0]              cnt_q, cnt_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [ACC_W-1:0]        prod_q, prod_d;
  logic [ACC_W-1:0]        tw_q, tw_d;
  logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [DAC_W-1:0]        p_q, p_d;
  wave_sel_e               sel_q, sel_d;
  logic                    sync_q, sync_d;
  logic [DAC_W-1:0]        dac_q, dac_d, sine_s;
  logic                    load_ok_s;

  assign fre_s     = {FRE6, FRE5, FRE4, FRE3, FRE2, FRE1, FRE0};
  assign load_ok_s = load && !bcd_invalid(fre_s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load_ok_s) state_d = ST_CONV; else state_d = ST_IDLE;
      ST_CONV:   if (cnt_q == 3'd6) state_d = ST_SCALE; else state_d = ST_CONV;
      ST_SCALE:  state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Digits are consumed MSD first from the top nibble of the snapshot.
  always_comb begin
    dig_d  = dig_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    prod_d = prod_q;
    tw_d   = tw_q;
    err_d  = err_q;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (load_ok_s) begin
          dig_d = fre_s;
          cnt_d = 3'd0;
          bin_d = {BIN_W{1'b0}};
        end else if (load) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_CONV: begin
        bin_d = bin_q * 24'd10 + BIN_W'(dig_q[4*BCD_DIGITS-1 -: 4]);
        dig_d = {dig_q[4*BCD_DIGITS-5:0], 4'd0};
        cnt_d = cnt_q + 3'd1;
      end
      ST_SCALE: begin
        prod_d = ACC_W'(({{(PROD_W-BIN_W){1'b0}}, bin_q} * SCALE_W) >> 5'd16);
      end
      ST_COMMIT: begin
        done_d = 1'b1;
        if (bin_q > FMAX_BIN) begin
          err_d = 1'b1;
        end else begin
          tw_d  = prod_q;
          err_d = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

`ifdef WAVE_SINE_EN
  logic [7:0]       lut_addr_s;
  logic [DAC_W-1:0] lut_data_s;

  // Second quadrant of each half walks the quarter table backwards.
  assign lut_addr_s = acc_q[ACC_W-2] ? ~acc_q[ACC_W-3 -: 8] : acc_q[ACC_W-3 -: 8];

  dac_sine_lut u_sine_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (lut_addr_s),
    .data  (lut_data_s)
  );

  assign sine_s = p_q[DAC_W-1] ? ~lut_data_s : lut_data_s;
`else
  assign sine_s = 10'd512;
`endif

  always_comb begin
    acc_d  = acc_q + tw_q;
    p_d    = acc_q[ACC_W-1 -: DAC_W];
    sel_d  = wave_sel_e'(wave_sel);
    sync_d = p_q[DAC_W-1];
    case (sel_q)
      WAVE_SQR: dac_d = p_q[DAC_W-1] ? {DAC_W{1'b1}} : {DAC_W{1'b0}};
      WAVE_SAW: dac_d = p_q;
      WAVE_TRI: dac_d = p_q[DAC_W-1] ? ~{p_q[DAC_W-2:0], 1'b0} : {p_q[DAC_W-2:0], 1'b0};
      WAVE_SIN: dac_d = sine_s;
      default:  dac_d = {DAC_W{1'b0}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_q  <= {(4*BCD_DIGITS){1'b0}};
      cnt_q  <= 3'd0;
      bin_q  <= {BIN_W{1'b0}};
      prod_q <= {ACC_W{1'b0}};
      tw_q   <= {ACC_W{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      acc_q  <= {ACC_W{1'b0}};
      p_q    <= {DAC_W{1'b0}};
      sel_q  <= WAVE_SQR;
      sync_q <= 1'b0;
      dac_q  <= {DAC_W{1'b0}};
    end else begin
      dig_q  <= dig_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      prod_q <= prod_d;
      tw_q   <= tw_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      acc_q  <= acc_d;
      p_q    <= p_d;
      sel_q  <= sel_d;
      sync_q <= sync_d;
      dac_q  <= dac_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign dac_out  = dac_q;
  assign sync_out = sync_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Scoreboard bench for dac_wave_gen: a cycle model built from frequency arithmetic and
// waveform formulas pushes expected outputs; a monitor pops and compares them.
module tb_dac_wave_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] fre [7];
  logic [1:0] wave_sel;
  logic       busy, done, err, sync_out;
  logic [9:0] dac_out;

  int checks   = 0;
  int failures = 0;
  longint cyc  = 0;

  typedef struct {
    int   dac;
    int   tol;
    logic sync;
    logic busy;
    logic done;
    logic err;
  } exp_t;

  exp_t   exp_q[$];
  longint commit_q[$];

  always #5 clk = ~clk;

  dac_wave_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .FRE0     (fre[0]),
    .FRE1     (fre[1]),
    .FRE2     (fre[2]),
    .FRE3     (fre[3]),
    .FRE4     (fre[4]),
    .FRE5     (fre[5]),
    .FRE6     (fre[6]),
    .load     (load),
    .wave_sel (wave_sel),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dac_out  (dac_out),
    .sync_out (sync_out)
  );

  task automatic check(input string name, input longint act, input longint expv, input int tol);
    longint d;
    checks++;
    d = (act > expv) ? act - expv : expv - act;
    if (d > tol) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, expv);
    end
  endtask

  // Ideal sample for phase index p (0..1023) and selector.
  function automatic int wave_value(input int p, input int sel);
    case (sel)
      0: return (p >= 512) ? 1023 : 0;
      1: return p;
      2: return (p < 512) ? 2 * p : 1023 - 2 * (p - 512);
`ifdef WAVE_SINE_EN
      3: return int'(511.5 + 511.5 * $sin(2.0 * 3.141592653589793 * real'(p) / 1024.0));
`else
      3: return 512;
`endif
      default: return 0;
    endcase
  endfunction

  // Reference model state.
  logic [31:0] m_acc, m_tw, pend_tw;
  logic        m_err, pend;
  longint      commit_at, pend_fre;
  int          h_p, h_sel;
  exp_t        me;

  initial begin
    m_acc = 32'd0; m_tw = 32'd0; m_err = 1'b0; pend = 1'b0;
    h_p = 0; h_sel = 0; commit_at = 0; pend_fre = 0; pend_tw = 32'd0;
    forever begin
      @(posedge clk);
      cyc++;
      me.done = 1'b0;
      me.tol  = 0;
      if (!rst_n) begin
        m_acc = 32'd0; m_tw = 32'd0; m_err = 1'b0; pend = 1'b0;
        h_p = 0; h_sel = 0;
        commit_q.delete();
        me.dac = 0; me.sync = 1'b0;
      end else begin
        me.dac  = wave_value(h_p, h_sel);
        me.sync = (h_p >= 512);
`ifdef WAVE_SINE_EN
        if (h_sel == 3) me.tol = 4;
`endif
        h_p   = int'(m_acc[31:22]);
        h_sel = int'(wave_sel);
        m_acc = m_acc + m_tw;
        if (pend && cyc == commit_at) begin
          if (pend_fre > 64'd9999999) m_err = 1'b1;
          else begin m_tw = pend_tw; m_err = 1'b0; end
          me.done = 1'b1;
          pend = 1'b0;
        end else if (!pend && load) begin
          bit bad;
          bad = 1'b0;
          pend_fre = 0;
          for (int k = 6; k >= 0; k--) begin
            if (fre[k] > 4'd9) bad = 1'b1;
            pend_fre = pend_fre * 10 + longint'(fre[k]);
          end
          if (bad) m_err = 1'b1;
          else begin
            pend      = 1'b1;
            commit_at = cyc + 9;
            pend_tw   = 32'((pend_fre * 64'd2814750) >> 16);
            commit_q.push_back(commit_at);
          end
        end
      end
      me.busy = pend;
      me.err  = m_err;
      exp_q.push_back(me);
    end
  end

  // Monitor: compares every presented sample and matches done pulses to commit slots.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dac_out", longint'(dac_out), longint'(e.dac), e.tol);
        check("sync_out", longint'(sync_out), longint'(e.sync), 0);
        check("busy", longint'(busy), longint'(e.busy), 0);
        check("done", longint'(done), longint'(e.done), 0);
        check("err", longint'(err), longint'(e.err), 0);
      end
      if (done === 1'b1) begin
        if (commit_q.size() == 0) check("done_unexpected", 1, 0, 0);
        else check("done_cycle", cyc, commit_q.pop_front(), 0);
      end
      if (commit_q.size() > 0 && commit_q[0] < cyc) begin
        check("done_missing", cyc, commit_q.pop_front(), 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_fre(input int f);
    int v;
    v = f;
    for (int k = 0; k < 7; k++) begin
      fre[k] = 4'(v % 10);
      v = v / 10;
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick(1);
    load = 1'b0;
    for (int k = 0; k < 7; k++) fre[k] = 4'($urandom_range(0, 15));
  endtask

  int hi;

  initial begin
    rst_n = 1'b0; load = 1'b0; wave_sel = 2'd0;
    set_fre(0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // 1000 Hz, then a 5000 Hz load while busy that must be ignored.
    wave_sel = 2'd1;
    set_fre(1000); pulse_load();
    tick(2);
    set_fre(5000); pulse_load();
    tick(30);
    for (int s = 0; s < 4; s++) begin
      wave_sel = 2'(s);
      tick(40);
    end

    // Non-BCD digit is rejected.
    set_fre(1000); fre[3] = 4'hA; pulse_load();
    tick(12);

    // Zero frequency freezes phase.
    set_fre(0); pulse_load();
    tick(25);

    // Reset in the middle of a conversion.
    set_fre(2000); pulse_load();
    tick(4);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    tick(20);

    // Triangle with p stepping by about one per clock.
    wave_sel = 2'd2;
    set_fre(97656); pulse_load();
    tick(1100);

    // Square duty over four periods.
    wave_sel = 2'd0;
    tick(20);
    hi = 0;
    for (int i = 0; i < 4096; i++) begin
      @(posedge clk); #1;
      if (dac_out == 10'd1023) hi++;
    end
    check("square_duty_high", longint'(hi), 2048, 16);

    wave_sel = 2'd3;
    tick(300);

    // Randomised loads, selectors, gaps and occasional resets.
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 7; k++) fre[k] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) fre[$urandom_range(0, 6)] = 4'($urandom_range(10, 15));
      wave_sel = 2'($urandom_range(0, 3));
      pulse_load();
      tick($urandom_range(1, 25));
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
      end
    end
    tick(40);

    check("pending_commits", longint'(commit_q.size()), 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
